// File: rtl/alu_pkg.sv
// Shared opcode constants, response FSM encoding and opcode legality check
// for the arbitrated ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= OP_XNOR);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational DW-bit ALU; zero latency, no flow control.
// Opcodes 110/111 return zero with illegal set.
module alu_core
  import alu_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    op,
  output logic [DW-1:0] result,
  output logic          illegal
);

  always_comb begin
    result  = '0;
    illegal = !is_legal_op(op);
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU among NREQ requesters; result one cycle after accept.
// Single-entry result register: stalls all requesters while full and rsp_ready is low.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DW   = 4,
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_a,
  input  logic [NREQ*DW-1:0]   req_b,
  input  logic [NREQ*3-1:0]    req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [DW-1:0]        rsp_result,
  output logic                 rsp_err
);

  state_t         state_q, state_d;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] cand;
  logic           found;
  logic           can_accept;
  logic           accept;
  logic [DW-1:0]  mux_a, mux_b, alu_result;
  logic [2:0]     mux_op;
  logic           alu_illegal;

  // Scan from farthest to nearest so the requester right after last_grant wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(last_grant) + k) % NREQ);
      if (req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign can_accept = (state_q == ST_EMPTY) || rsp_ready;
  assign accept     = found && can_accept;

  always_comb begin
    req_ready = '0;
    if (found) req_ready[winner] = can_accept;
  end

  assign mux_a  = req_a[int'(winner)*DW +: DW];
  assign mux_b  = req_b[int'(winner)*DW +: DW];
  assign mux_op = req_op[int'(winner)*3 +: 3];

  alu_core #(.DW(DW)) u_alu_core (
    .a       (mux_a),
    .b       (mux_b),
    .op      (mux_op),
    .result  (alu_result),
    .illegal (alu_illegal)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (!accept && rsp_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      last_grant <= IDW'(NREQ - 1);
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant <= winner;
        rsp_id     <= winner;
        rsp_result <= alu_result;
        rsp_err    <= alu_illegal;
      end
    end
  end

  assign rsp_valid = (state_q == ST_FULL);

endmodule
